// File: rtl/adder_share_arbiter_if.sv
// Handshake bundle between two add/sub requesters, the shared adder and writeback.
// ADD_ARB_FLAGS_EN adds the zero/carry/overflow result flags.
interface adder_share_arbiter_if #(
   parameter int WIDTH = 32
);
   logic             req0_valid_i;
   logic             req0_ready_o;
   logic [WIDTH-1:0] req0_a_i;
   logic [WIDTH-1:0] req0_b_i;
   logic             req0_sub_i;
   logic             req1_valid_i;
   logic             req1_ready_o;
   logic [WIDTH-1:0] req1_a_i;
   logic [WIDTH-1:0] req1_b_i;
   logic             req1_sub_i;
   logic             res_valid_o;
   logic             res_ready_i;
   logic [WIDTH-1:0] res_sum_o;
   logic             res_id_o;
`ifdef ADD_ARB_FLAGS_EN
   logic             res_zero_o;
   logic             res_cout_o;
   logic             res_ovf_o;
`endif

   modport slave (
      input  req0_valid_i, req0_a_i, req0_b_i, req0_sub_i,
      input  req1_valid_i, req1_a_i, req1_b_i, req1_sub_i,
      input  res_ready_i,
      output req0_ready_o, req1_ready_o,
`ifdef ADD_ARB_FLAGS_EN
      output res_zero_o, res_cout_o, res_ovf_o,
`endif
      output res_valid_o, res_sum_o, res_id_o
   );

   modport master (
      output req0_valid_i, req0_a_i, req0_b_i, req0_sub_i,
      output req1_valid_i, req1_a_i, req1_b_i, req1_sub_i,
      output res_ready_i,
      input  req0_ready_o, req1_ready_o,
`ifdef ADD_ARB_FLAGS_EN
      input  res_zero_o, res_cout_o, res_ovf_o,
`endif
      input  res_valid_o, res_sum_o, res_id_o
   );
endinterface

// File: rtl/adder_share_arbiter.sv
// One add/sub datapath shared round-robin by two requesters, 1-deep result stage.
// Optional ADD_ARB_FLAGS_EN registers zero/carry/overflow flags with the sum.
module adder_share_arbiter #(
   parameter int WIDTH     = 32,
   parameter bit PRIO_INIT = 1'b0
) (
   input logic                 clk_i,
   input logic                 rst_i,
   adder_share_arbiter_if.slave bus
);
   logic             last_grant;
   logic             grant0;
   logic             grant1;
   logic             can_accept;
   logic             accept;
   logic             pick;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_bx;
   logic             op_sub;
   logic [WIDTH:0]   sum_full;

   // Ties go to whoever was not served last; a stalled grant never rotates.
   always_comb begin
      grant0 = bus.req0_valid_i & (!bus.req1_valid_i | last_grant);
      grant1 = bus.req1_valid_i & (!bus.req0_valid_i | !last_grant);
   end

   assign can_accept       = !bus.res_valid_o | bus.res_ready_i;
   assign bus.req0_ready_o = grant0 & can_accept & !rst_i;
   assign bus.req1_ready_o = grant1 & can_accept & !rst_i;
   assign accept           = bus.req0_ready_o | bus.req1_ready_o;
   assign pick             = bus.req1_ready_o;

   always_comb begin
      op_a   = bus.req0_a_i;
      op_sub = bus.req0_sub_i;
      op_bx  = bus.req0_b_i ^ {WIDTH{bus.req0_sub_i}};
      if (pick) begin
         op_a   = bus.req1_a_i;
         op_sub = bus.req1_sub_i;
         op_bx  = bus.req1_b_i ^ {WIDTH{bus.req1_sub_i}};
      end
      sum_full = {1'b0, op_a} + {1'b0, op_bx} + {{WIDTH{1'b0}}, op_sub};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bus.res_valid_o <= 1'b0;
         bus.res_sum_o   <= '0;
         bus.res_id_o    <= 1'b0;
         last_grant      <= ~PRIO_INIT;
      end else if (accept) begin
         bus.res_valid_o <= 1'b1;
         bus.res_sum_o   <= sum_full[WIDTH-1:0];
         bus.res_id_o    <= pick;
         last_grant      <= pick;
      end else if (bus.res_ready_i) begin
         bus.res_valid_o <= 1'b0;
      end
   end

`ifdef ADD_ARB_FLAGS_EN
   logic zero_n;
   logic ovf_n;

   assign zero_n = (sum_full[WIDTH-1:0] == '0);
   assign ovf_n  = (op_a[WIDTH-1] == op_bx[WIDTH-1])
                 & (sum_full[WIDTH-1] != op_a[WIDTH-1]);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bus.res_zero_o <= 1'b0;
         bus.res_cout_o <= 1'b0;
         bus.res_ovf_o  <= 1'b0;
      end else if (accept) begin
         bus.res_zero_o <= zero_n;
         bus.res_cout_o <= sum_full[WIDTH];
         bus.res_ovf_o  <= ovf_n;
      end
   end
`endif
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Randomized bench for adder_share_arbiter against a transaction-level model.
// Flag checks are compiled in when ADD_ARB_FLAGS_EN is defined.
module tb_adder_share_arbiter;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   adder_share_arbiter_if #(.WIDTH(W)) bus ();

   adder_share_arbiter #(.WIDTH(W), .PRIO_INIT(1'b0)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   logic         v0, v1, s0, s1, rr;
   logic [W-1:0] a0, b0, a1, b1;

   // model: who was served last, and the result waiting for writeback
   logic         m_last;
   logic         m_valid;
   logic [W-1:0] m_sum;
   logic         m_id;
   logic         m_zero, m_cout, m_ovf;
   logic         e_r0, e_r1;

   function automatic logic [W-1:0] ref_op(logic [W-1:0] a, logic [W-1:0] b, logic sub);
      return sub ? a - b : a + b;
   endfunction

   task automatic apply();
      bus.req0_valid_i = v0;
      bus.req0_a_i     = a0;
      bus.req0_b_i     = b0;
      bus.req0_sub_i   = s0;
      bus.req1_valid_i = v1;
      bus.req1_a_i     = a1;
      bus.req1_b_i     = b1;
      bus.req1_sub_i   = s1;
      bus.res_ready_i  = rr;
   endtask

   task automatic predict();
      logic room;
      room = !m_valid || rr;
      e_r0 = 1'b0;
      e_r1 = 1'b0;
      if (!rst && room) begin
         if (v0 && v1) begin
            if (m_last) e_r0 = 1'b1;
            else        e_r1 = 1'b1;
         end else begin
            e_r0 = v0;
            e_r1 = v1;
         end
      end
   endtask

   task automatic commit();
      logic [W-1:0] a, b;
      logic         sub;
      longint       exact;
      if (rst) begin
         m_valid = 1'b0; m_sum = '0; m_id = 1'b0; m_last = 1'b1;
         m_zero = 1'b0; m_cout = 1'b0; m_ovf = 1'b0;
      end else if (e_r0 || e_r1) begin
         a   = e_r1 ? a1 : a0;
         b   = e_r1 ? b1 : b0;
         sub = e_r1 ? s1 : s0;
         m_valid = 1'b1;
         m_sum   = ref_op(a, b, sub);
         m_id    = e_r1;
         m_last  = e_r1;
         m_zero  = (m_sum == 0);
         m_cout  = sub ? (a >= b) : (({1'b0, a} + {1'b0, b}) >> W) != 0;
         exact   = sub ? longint'($signed(a)) - longint'($signed(b))
                       : longint'($signed(a)) + longint'($signed(b));
         m_ovf   = (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
      end else if (rr) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic step();
      apply();
      #1;
      predict();
   endtask

   task automatic edge_();
      @(posedge clk);
      #1;
      commit();
   endtask

   task automatic new_op0();
      a0 = $urandom; b0 = $urandom; s0 = 1'($urandom_range(0, 1));
   endtask

   task automatic new_op1();
      a1 = $urandom; b1 = $urandom; s1 = 1'($urandom_range(0, 1));
   endtask

   task automatic test_reset();
      rst = 1'b1; v0 = 1'b1; v1 = 1'b1; rr = 1'b1;
      new_op0(); new_op1();
      step();
      checks++;
      if (bus.req0_ready_o !== 1'b0 || bus.req1_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready got %b%b want 00", bus.req0_ready_o, bus.req1_ready_o);
      end
      edge_();
      checks++;
      if (bus.res_valid_o !== 1'b0 || bus.res_sum_o !== '0 || bus.res_id_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_out got v=%b s=%h id=%b want 0 0 0",
                  bus.res_valid_o, bus.res_sum_o, bus.res_id_o);
      end
      rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
   endtask

   task automatic test_single();
      v0 = 1'b1; a0 = 5; b0 = 3; s0 = 1'b0; v1 = 1'b0; rr = 1'b1;
      step();
      checks++;
      if (bus.req0_ready_o !== 1'b1 || bus.req1_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL single_ready got %b%b want 10", bus.req0_ready_o, bus.req1_ready_o);
      end
      edge_();
      v0 = 1'b0;
      checks++;
      if (bus.res_valid_o !== 1'b1 || bus.res_sum_o !== 32'd8 || bus.res_id_o !== 1'b0) begin
         errors++;
         $display("FAIL single_out got v=%b s=%h id=%b want 1 8 0",
                  bus.res_valid_o, bus.res_sum_o, bus.res_id_o);
      end
   endtask

   task automatic test_alternate();
      rst = 1'b1;
      step();
      edge_();
      rst = 1'b0; v0 = 1'b1; v1 = 1'b1; rr = 1'b1;
      new_op0(); new_op1();
      for (int i = 0; i < 8; i++) begin
         step();
         checks++;
         if (bus.req0_ready_o !== ((i % 2) == 0) || bus.req1_ready_o !== ((i % 2) == 1)) begin
            errors++;
            $display("FAIL alt_grant[%0d] got %b%b want %b%b", i,
                     bus.req0_ready_o, bus.req1_ready_o, (i % 2) == 0, (i % 2) == 1);
         end
         edge_();
         checks++;
         if (bus.res_valid_o !== 1'b1 || bus.res_sum_o !== m_sum || bus.res_id_o !== m_id) begin
            errors++;
            $display("FAIL alt_out[%0d] got v=%b s=%h id=%b want 1 %h %b", i,
                     bus.res_valid_o, bus.res_sum_o, bus.res_id_o, m_sum, m_id);
         end
         if (e_r0) new_op0();
         if (e_r1) new_op1();
      end
   endtask

   task automatic test_stall();
      rr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (bus.req0_ready_o !== 1'b0 || bus.req1_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_ready[%0d] got %b%b want 00", i,
                     bus.req0_ready_o, bus.req1_ready_o);
         end
         edge_();
         checks++;
         if (bus.res_valid_o !== 1'b1 || bus.res_sum_o !== m_sum || bus.res_id_o !== m_id) begin
            errors++;
            $display("FAIL stall_hold[%0d] got v=%b s=%h id=%b want 1 %h %b", i,
                     bus.res_valid_o, bus.res_sum_o, bus.res_id_o, m_sum, m_id);
         end
      end
      rr = 1'b1;
      step();
      checks++;
      if ({bus.req0_ready_o, bus.req1_ready_o} !== {e_r0, e_r1} || !(e_r0 || e_r1)) begin
         errors++;
         $display("FAIL drain_refill_ready got %b%b want %b%b",
                  bus.req0_ready_o, bus.req1_ready_o, e_r0, e_r1);
      end
      edge_();
      checks++;
      if (bus.res_valid_o !== 1'b1 || bus.res_sum_o !== m_sum || bus.res_id_o !== m_id) begin
         errors++;
         $display("FAIL drain_refill_out got v=%b s=%h id=%b want 1 %h %b",
                  bus.res_valid_o, bus.res_sum_o, bus.res_id_o, m_sum, m_id);
      end
      v0 = 1'b0; v1 = 1'b0;
   endtask

   task automatic test_sub();
      logic [W-1:0] as [2];
      logic [W-1:0] want [2];
      logic         ovf [2];
      as[0] = 32'h0;         want[0] = 32'hFFFF_FFFF; ovf[0] = 1'b0;
      as[1] = 32'h8000_0000; want[1] = 32'h7FFF_FFFF; ovf[1] = 1'b1;
      rr = 1'b1; v0 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         v1 = 1'b1; a1 = as[i]; b1 = 32'd1; s1 = 1'b1;
         step();
         edge_();
         v1 = 1'b0;
         checks++;
         if (bus.res_valid_o !== 1'b1 || bus.res_sum_o !== want[i] || bus.res_id_o !== 1'b1) begin
            errors++;
            $display("FAIL sub[%0d] got v=%b s=%h id=%b want 1 %h 1", i,
                     bus.res_valid_o, bus.res_sum_o, bus.res_id_o, want[i]);
         end
`ifdef ADD_ARB_FLAGS_EN
         checks++;
         if (bus.res_ovf_o !== ovf[i] || bus.res_zero_o !== 1'b0
             || bus.res_cout_o !== (i == 1)) begin
            errors++;
            $display("FAIL sub_flags[%0d] got z=%b c=%b o=%b want 0 %b %b", i,
                     bus.res_zero_o, bus.res_cout_o, bus.res_ovf_o, i == 1, ovf[i]);
         end
`endif
      end
   endtask

   task automatic test_random();
      v0 = 1'b0; v1 = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!v0) begin v0 = 1'($urandom_range(0, 1)); new_op0(); end
         if (!v1) begin v1 = 1'($urandom_range(0, 1)); new_op1(); end
         if ((i % 37) == 5) begin a0 = b0; s0 = 1'b1; end
         rr = ($urandom_range(0, 3) != 0);
         step();
         checks++;
         if (bus.req0_ready_o !== e_r0 || bus.req1_ready_o !== e_r1) begin
            errors++;
            $display("FAIL rnd_ready[%0d] got %b%b want %b%b", i,
                     bus.req0_ready_o, bus.req1_ready_o, e_r0, e_r1);
         end
         edge_();
         checks++;
         if (bus.res_valid_o !== m_valid || bus.res_sum_o !== m_sum || bus.res_id_o !== m_id) begin
            errors++;
            $display("FAIL rnd_out[%0d] got v=%b s=%h id=%b want %b %h %b", i,
                     bus.res_valid_o, bus.res_sum_o, bus.res_id_o, m_valid, m_sum, m_id);
         end
`ifdef ADD_ARB_FLAGS_EN
         checks++;
         if (bus.res_zero_o !== m_zero || bus.res_cout_o !== m_cout || bus.res_ovf_o !== m_ovf) begin
            errors++;
            $display("FAIL rnd_flags[%0d] got z=%b c=%b o=%b want %b %b %b", i,
                     bus.res_zero_o, bus.res_cout_o, bus.res_ovf_o, m_zero, m_cout, m_ovf);
         end
`endif
         if (e_r0) v0 = 1'b0;
         if (e_r1) v1 = 1'b0;
      end
      v0 = 1'b0; v1 = 1'b0;
   endtask

   task automatic test_reset_mid();
      v0 = 1'b0; v1 = 1'b1; new_op1(); rr = 1'b1;
      step();
      edge_();
      v0 = 1'b1; v1 = 1'b1; new_op0(); new_op1(); rr = 1'b0;
      step();
      edge_();
      rr = 1'b1; rst = 1'b1;
      step();
      checks++;
      if (bus.req0_ready_o !== 1'b0 || bus.req1_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_ready got %b%b want 00", bus.req0_ready_o, bus.req1_ready_o);
      end
      edge_();
      checks++;
      if (bus.res_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_valid got %b want 0", bus.res_valid_o);
      end
      rst = 1'b0;
      step();
      checks++;
      if (bus.req0_ready_o !== 1'b1 || bus.req1_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_prio got %b%b want 10", bus.req0_ready_o, bus.req1_ready_o);
      end
      edge_();
      checks++;
      if (bus.res_valid_o !== 1'b1 || bus.res_id_o !== 1'b0 || bus.res_sum_o !== m_sum) begin
         errors++;
         $display("FAIL rstmid_out got v=%b s=%h id=%b want 1 %h 0",
                  bus.res_valid_o, bus.res_sum_o, bus.res_id_o, m_sum);
      end
      v0 = 1'b0; v1 = 1'b0;
   endtask

   initial begin
      m_last = 1'b1; m_valid = 1'b0; m_sum = '0; m_id = 1'b0;
      m_zero = 1'b0; m_cout = 1'b0; m_ovf = 1'b0;
      v0 = 1'b0; v1 = 1'b0; rr = 1'b1;
      a0 = '0; b0 = '0; s0 = 1'b0; a1 = '0; b1 = '0; s1 = 1'b0;
      apply();
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_alternate();
      test_stall();
      test_sub();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
